dmem_arbiter: RTL

- Shares the single-port data RAM (12-bit address, 32-bit data, synchronous read, 1-cycle latency) between the processor and one external requester (loader/debug/DMA).
- The processor has priority. A starvation counter guarantees the external side a slot within MAX_WAIT cycles. When the processor loses a slot, it is stalled.
- Sits between processor/RAM in the top-level wrapper; steers write strobes, address and write data to the RAM, and steers read data back to its owner.

---
 rtl/dmem_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data RAM between the processor and an external
// requester. The processor has priority; a starvation counter bounds the external wait.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_owner_ext_q, rd_owner_ext_d;
  logic       rd_owner_cpu_q, rd_owner_cpu_d;
  logic       grant_ext, grant_cpu;

  always_comb begin
    grant_ext  = !reset && ext_req && (!cpu_req || (wait_cnt_q == MAX_CNT));
    grant_cpu  = !reset && cpu_req && !grant_ext;

    ram_addr   = cpu_addr;
    ram_dataIn = cpu_wdata;
    ram_wEn    = grant_cpu && cpu_wren;
    if (grant_ext) begin
      ram_addr   = ext_addr;
      ram_dataIn = ext_wdata;
      ram_wEn    = ext_we;
    end

    wait_cnt_d = wait_cnt_q;
    if (grant_ext || !ext_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_CNT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    rd_owner_ext_d = grant_ext && !ext_we;
    rd_owner_cpu_d = grant_cpu && !cpu_wren;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q     <= '0;
      rd_owner_ext_q <= 1'b0;
      rd_owner_cpu_q <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      rd_owner_ext_q <= rd_owner_ext_d;
      rd_owner_cpu_q <= rd_owner_cpu_d;
    end
  end

  // Gating with reset drops a read that was accepted just before reset arrived.
  assign ext_rvalid = rd_owner_ext_q && !reset;
  assign ext_rdata  = ext_rvalid ? ram_dataOut : '0;
  assign ext_ack    = grant_ext;
  assign cpu_stall  = cpu_req && grant_ext;
  assign cpu_rdata  = ram_dataOut;

  // Only one side can own the read data returning in any cycle.
  a_one_owner: assert property (@(posedge clock) disable iff (reset)
    !(rd_owner_ext_q && rd_owner_cpu_q));

endmodule
